// File: rtl/hilo_mul_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// hilo_mul_ctrl_pkg
// Shared definitions for the HI/LO multiply controller:
//   - op_code values for the HI/LO-class operations presented by EXE
//   - controller state encoding
//   - small decode helper used by the controller
// ----------------------------------------------------------------------------
package hilo_mul_ctrl_pkg;

  // HI/LO-class operation codes carried on op_code
  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_MTHI  = 3'd2;
  localparam logic [2:0] OP_MTLO  = 3'd3;
  localparam logic [2:0] OP_MFHI  = 3'd4;
  localparam logic [2:0] OP_MFLO  = 3'd5;

  // Controller state encoding
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  // True for the two op codes that launch the multiplier
  function automatic logic is_mult_op(input logic [2:0] code);
    return (code == OP_MULT) || (code == OP_MULTU);
  endfunction

endpackage

// File: rtl/hilo_mul_ctrl_if.sv
// ----------------------------------------------------------------------------
// hilo_mul_ctrl_if
// Pipeline-side bundle between the EXE stage (master) and the HI/LO multiply
// controller (slave).
//   op_valid  master->slave  EXE presents an HI/LO-class op
//   op_code   master->slave  op select (see hilo_mul_ctrl_pkg)
//   op_rs     master->slave  rs value (operand 1 / MTHI / MTLO data)
//   op_rt     master->slave  rt value (operand 2)
//   flush     master->slave  exception/cancel, aborts an in-flight multiply
//   op_ready  slave->master  op taken on a cycle with op_valid & op_ready
//   mf_data   slave->master  HI or LO read data, combinational on op_code
// ----------------------------------------------------------------------------
interface hilo_mul_ctrl_if;

  logic        op_valid;
  logic [2:0]  op_code;
  logic [31:0] op_rs;
  logic [31:0] op_rt;
  logic        flush;
  logic        op_ready;
  logic [31:0] mf_data;

  modport master (
    output op_valid, op_code, op_rs, op_rt, flush,
    input  op_ready, mf_data
  );

  modport slave (
    input  op_valid, op_code, op_rs, op_rt, flush,
    output op_ready, mf_data
  );

endinterface

// File: rtl/hilo_mul_ctrl.sv
// ----------------------------------------------------------------------------
// hilo_mul_ctrl
// EXE-stage controller for MULT/MULTU/MTHI/MTLO/MFHI/MFLO. It launches the
// sequential multiplier, holds mult_begin for the whole operation, writes the
// 64-bit product into HI/LO and stalls the pipeline while a multiply runs.
//
// Ports:
//   clk            clock, all state on rising edge
//   resetn         asynchronous active-low reset
//   pipe           pipeline bundle (op_valid/op_code/op_rs/op_rt/flush in,
//                  op_ready/mf_data out)
//   hi, lo         architectural HI/LO registers
//   mult_begin     registered start/hold to the multiplier
//   mult_unsigned  registered mode to the multiplier, 1 = unsigned
//   mult_op1/2     registered operands to the multiplier
//   mult_product   multiplier 64-bit result
//   mult_end       multiplier single-cycle done pulse
// ----------------------------------------------------------------------------
module hilo_mul_ctrl
  import hilo_mul_ctrl_pkg::*;
#(
  parameter logic [31:0] HI_RST = 32'h0000_0000,
  parameter logic [31:0] LO_RST = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  resetn,
  hilo_mul_ctrl_if.slave        pipe,
  output logic [31:0]           hi,
  output logic [31:0]           lo,
  output logic                  mult_begin,
  output logic                  mult_unsigned,
  output logic [31:0]           mult_op1,
  output logic [31:0]           mult_op2,
  input  logic [63:0]           mult_product,
  input  logic                  mult_end
);

  state_e      state_q, state_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] op1_q, op1_d;
  logic [31:0] op2_q, op2_d;
  logic        begin_q, begin_d;
  logic        unsigned_q, unsigned_d;
  logic        accept_s;
  logic        op_ready_s;
  logic [31:0] mf_data_s;

  // flush blocks acceptance even while op_ready is shown high
  assign accept_s = pipe.op_valid && (state_q == IDLE) && !pipe.flush;

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; flush wins over mult_end while BUSY
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept_s && is_mult_op(pipe.op_code)) begin
          state_d = BUSY;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (pipe.flush) begin
          state_d = DRAIN;
        end else if (mult_end) begin
          state_d = IDLE;
        end else begin
          state_d = BUSY;
        end
      end
      // one dead cycle lets the multiplier's internal valid clear
      DRAIN:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Pipeline-facing outputs; non-MF codes read LO so mf_data is deterministic
  always_comb begin
    op_ready_s = (state_q == IDLE);
    if (pipe.op_code == OP_MFHI) begin
      mf_data_s = hi_q;
    end else begin
      mf_data_s = lo_q;
    end
  end

  // HI/LO and multiplier-interface next values
  always_comb begin
    hi_d       = hi_q;
    lo_d       = lo_q;
    op1_d      = op1_q;
    op2_d      = op2_q;
    begin_d    = begin_q;
    unsigned_d = unsigned_q;
    case (state_q)
      IDLE: begin
        begin_d = 1'b0;
        if (accept_s) begin
          case (pipe.op_code)
            OP_MULT, OP_MULTU: begin
              op1_d      = pipe.op_rs;
              op2_d      = pipe.op_rt;
              unsigned_d = (pipe.op_code == OP_MULTU);
              begin_d    = 1'b1;
            end
            OP_MTHI: hi_d = pipe.op_rs;
            OP_MTLO: lo_d = pipe.op_rs;
            default: begin
              hi_d = hi_q;
              lo_d = lo_q;
            end
          endcase
        end else begin
          begin_d = 1'b0;
        end
      end
      BUSY: begin
        // begin must fall on the completing edge or the multiplier restarts
        if (pipe.flush) begin
          begin_d = 1'b0;
        end else if (mult_end) begin
          hi_d    = mult_product[63:32];
          lo_d    = mult_product[31:0];
          begin_d = 1'b0;
        end else begin
          begin_d = 1'b1;
        end
      end
      DRAIN:   begin_d = 1'b0;
      default: begin_d = 1'b0;
    endcase
  end

  // HI/LO and multiplier-interface registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hi_q       <= HI_RST;
      lo_q       <= LO_RST;
      op1_q      <= 32'h0000_0000;
      op2_q      <= 32'h0000_0000;
      begin_q    <= 1'b0;
      unsigned_q <= 1'b0;
    end else begin
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      op1_q      <= op1_d;
      op2_q      <= op2_d;
      begin_q    <= begin_d;
      unsigned_q <= unsigned_d;
    end
  end

  assign pipe.op_ready = op_ready_s;
  assign pipe.mf_data  = mf_data_s;
  assign hi            = hi_q;
  assign lo            = lo_q;
  assign mult_begin    = begin_q;
  assign mult_unsigned = unsigned_q;
  assign mult_op1      = op1_q;
  assign mult_op2      = op2_q;

endmodule
